// File: rtl/fifo_rd_stream_adapter.sv
// Read-side drain of the async FIFO: rd_en/empty/registered-rdata in, valid/ready stream out.
// Latency: empty falling in cycle N gives rd_en in N and m_valid_o in N+2; 1 word/cycle steady state.
// Backpressure: a 2-entry skid buffer absorbs the in-flight read; rd_en stalls once buffered + in-flight reach 2.
//
// Ports:
//   clk_i, rst_i     read-domain clock, asynchronous active-high reset
//   fifo_empty_i     FIFO empty flag
//   fifo_rd_en_o     FIFO read request (combinational, depends on m_ready_i)
//   fifo_rdata_i     FIFO read data, valid the cycle after fifo_rd_en_o
//   m_valid_o/m_ready_i/m_data_o/m_last_o   output stream; m_last_o marks word BURST_LEN of each burst
//   word_cnt_o       count of accepted stream words, wraps
module fifo_rd_stream_adapter #(
  parameter int DATA_WIDTH = 12,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic [CNT_WIDTH-1:0]  word_cnt_o
);

  localparam int                BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

  logic [1:0]            occ_q;
  logic [1:0]            occ_d;
  logic                  inflight_q;
  logic [BEAT_W-1:0]     beat_q;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  hs;
  logic                  push;
  logic [1:0]            credit;

  assign m_valid_o  = (occ_q != 2'd0);
  assign hs         = m_valid_o & m_ready_i;
  assign push       = inflight_q;
  assign m_data_o   = head_q;
  assign m_last_o   = m_valid_o & (beat_q == BEAT_MAX);
  assign word_cnt_o = cnt_q;

  // Slots committed after this edge: buffered + in flight - leaving now.
  // occ + inflight never exceeds 2, so two bits are enough.
  assign credit       = occ_q + {1'b0, inflight_q} - {1'b0, hs};
  assign fifo_rd_en_o = !rst_i & !fifo_empty_i & (credit < 2'd2);

  always_comb begin
    occ_d = occ_q;
    case ({push, hs})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      beat_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= fifo_rd_en_o;

      // head_q is always the oldest word; tail_q is only meaningful at occ=2.
      if (hs) begin
        if (push && (occ_q == 2'd1)) begin
          head_q <= fifo_rdata_i;
        end else begin
          head_q <= tail_q;
          if (push) begin
            tail_q <= fifo_rdata_i;
          end
        end
      end else if (push) begin
        if (occ_q == 2'd0) begin
          head_q <= fifo_rdata_i;
        end else begin
          tail_q <= fifo_rdata_i;
        end
      end

      if (hs) begin
        cnt_q  <= cnt_q + 1'b1;
        beat_q <= (beat_q == BEAT_MAX) ? '0 : beat_q + 1'b1;
      end
    end
  end

  // The read credit rule leaves a free slot for every in-flight word.
  a_no_capture_when_full: assert property (
    @(posedge clk_i) disable iff (rst_i) !(inflight_q && (occ_q == 2'd2))
  );

endmodule
